debounce_edge: RTL

//   Conditions a raw asynchronous input (pushbutton/switch) for the synchronous flip-flop stages downstream.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_edge_sync_chain.sv | 29 ++
 rtl/debounce_edge.sv | 131 +++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the debounce_edge block: FSM state encodings, legal
// synchroniser depth range and a small state-decode helper.
package debounce_pkg;

  localparam logic [1:0] ST_IDLE_LO = 2'd0;
  localparam logic [1:0] ST_ARM_HI  = 2'd1;
  localparam logic [1:0] ST_IDLE_HI = 2'd2;
  localparam logic [1:0] ST_ARM_LO  = 2'd3;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic logic is_arm_state(input logic [1:0] st);
    return (st == ST_ARM_HI) || (st == ST_ARM_LO);
  endfunction

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// sync_chain: STAGES-deep flop synchroniser bringing an asynchronous input
// into the clk domain; every stage resets asynchronously to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: synchronises and debounces btn_in, driving a registered level
// plus one-cycle edge pulses. Macro DEBOUNCE_FALL_PULSE_EN enables fall_pulse.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
      $error("debounce_edge: SYNC_STAGES out of legal range 2..4");
    end
    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_stable_cycles
      $error("debounce_edge: STABLE_CYCLES must be >= 1 and < 2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_s;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             level_d, level_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic             busy_d, busy_q;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_chain (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_s)
  );

  // Counter leaves ARM through the FSM exit, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE_LO: begin
        cnt_d = '0;
        if (sync_s) begin
          state_d = ST_ARM_HI;
        end else begin
          state_d = ST_IDLE_LO;
        end
      end
      ST_ARM_HI: begin
        if (!sync_s) begin
          state_d = ST_IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE_HI: begin
        cnt_d = '0;
        if (!sync_s) begin
          state_d = ST_ARM_LO;
        end else begin
          state_d = ST_IDLE_HI;
        end
      end
      ST_ARM_LO: begin
        if (sync_s) begin
          state_d = ST_IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
          fall_d  = 1'b1;
`else
          fall_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    busy_d = is_arm_state(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule
